// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, FPU sequencer state encoding
// and the default FPU response timeout.
package core_pkg;

  localparam int BUS_WIDTH      = 64;
  localparam int REGFILE_LEN    = 6;
  localparam int FPU_OP_WIDTH   = 5;
  localparam int TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fpu_state_e;

endpackage

// File: rtl/ex_fpu_timer.sv
// 8-bit clear/increment counter; tc flags that the count equals TERMINAL.
module ex_fpu_timer #(
  parameter logic [7:0] TERMINAL = 8'd254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 8'd0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/ex_fpu_seq.sv
// EX-stage sequencer: holds the pipeline while one instruction is handed to
// an external FPU, then returns its result to EX/MEM as a one-cycle strobe.
module ex_fpu_seq #(
  parameter int BUS_WIDTH      = core_pkg::BUS_WIDTH,
  parameter int REGFILE_LEN    = core_pkg::REGFILE_LEN,
  parameter int FPU_OP_WIDTH   = core_pkg::FPU_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = core_pkg::TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_alu_fpu,
  input  logic [FPU_OP_WIDTH-1:0] in_fpu_op,
  input  logic [BUS_WIDTH-1:0]    in_a,
  input  logic [BUS_WIDTH-1:0]    in_b,
  input  logic [REGFILE_LEN-1:0]  in_rd,
  input  logic                    in_reg_write,
  input  logic                    flush,
  output logic                    fpu_req_valid,
  input  logic                    fpu_req_ready,
  output logic [FPU_OP_WIDTH-1:0] fpu_op,
  output logic [BUS_WIDTH-1:0]    fpu_a,
  output logic [BUS_WIDTH-1:0]    fpu_b,
  input  logic                    fpu_resp_valid,
  input  logic [BUS_WIDTH-1:0]    fpu_result,
  output logic                    stall,
  output logic                    out_valid,
  output logic [BUS_WIDTH-1:0]    out_result,
  output logic [REGFILE_LEN-1:0]  out_rd,
  output logic                    out_reg_write,
  output logic                    busy,
  output logic                    timeout_err
);

  import core_pkg::*;

  // The timer counts completed WAIT cycles from zero, so the abort fires in
  // the WAIT cycle whose count is one below the configured limit.
  localparam logic [7:0] TIMER_TERMINAL = 8'(TIMEOUT_CYCLES - 1);

  fpu_state_e             state;
  logic [REGFILE_LEN-1:0] rd_q;
  logic                   reg_write_q;
  logic                   kill;
  logic                   out_valid_q;
  logic                   out_reg_write_q;
  logic                   start;
  logic                   kill_now;
  logic                   timer_clr;
  logic                   timer_inc;
  logic                   timer_tc;

  assign start    = in_valid & in_alu_fpu & ~flush;
  assign kill_now = kill | flush;

  // Request handshake: fpu_req_valid is high for the whole ISSUE state with
  // fpu_op/a/b held constant; the request transfers on the first cycle where
  // fpu_req_valid & fpu_req_ready. fpu_resp_valid is a one-cycle pulse that
  // is only honoured in WAIT.
  assign fpu_req_valid = (state == ST_ISSUE);
  assign stall = ((state == ST_IDLE) & start) | (state == ST_ISSUE) | (state == ST_WAIT);

  assign timer_clr = ((state == ST_IDLE) & start) | ((state == ST_ISSUE) & fpu_req_ready);
  assign timer_inc = (state == ST_WAIT) & ~fpu_resp_valid;

  ex_fpu_timer #(
    .TERMINAL (TIMER_TERMINAL)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .inc (timer_inc),
    .tc  (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      fpu_op          <= '0;
      fpu_a           <= '0;
      fpu_b           <= '0;
      rd_q            <= '0;
      reg_write_q     <= 1'b0;
      kill            <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      out_valid_q     <= 1'b0;
      out_reg_write_q <= 1'b0;
      out_result      <= '0;
      out_rd          <= '0;
    end else begin
      out_valid_q     <= 1'b0;
      out_reg_write_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            fpu_op      <= in_fpu_op;
            fpu_a       <= in_a;
            fpu_b       <= in_b;
            rd_q        <= in_rd;
            reg_write_q <= in_reg_write;
            kill        <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (flush) kill <= 1'b1;
          if (fpu_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (flush) kill <= 1'b1;
          if (fpu_resp_valid) begin
            if (!kill_now) out_result <= fpu_result;
            out_valid_q     <= ~kill_now;
            out_reg_write_q <= reg_write_q & ~kill_now;
            out_rd          <= rd_q;
            state           <= ST_DONE;
          end else if (timer_tc) begin
            timeout_err     <= 1'b1;
            out_result      <= '0;
            out_valid_q     <= ~kill_now;
            out_reg_write_q <= reg_write_q & ~kill_now;
            out_rd          <= rd_q;
            state           <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A flush arriving in the DONE cycle itself still has to kill the strobe.
  assign out_valid     = out_valid_q & ~flush;
  assign out_reg_write = out_reg_write_q & ~flush;

endmodule

// File: tb/tb_ex_fpu_seq.sv
// Randomised bench for ex_fpu_seq: a transaction-level timing/result model
// predicts stall, request, strobe and timeout behaviour for every instruction.
module tb_ex_fpu_seq;

  localparam int BW = 64;
  localparam int RL = 6;
  localparam int OW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_alu_fpu = 1'b0;
  logic [OW-1:0] in_fpu_op = '0;
  logic [BW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic [RL-1:0] in_rd = '0;
  logic          in_reg_write = 1'b0;
  logic          flush = 1'b0;
  logic          fpu_req_valid;
  logic          fpu_req_ready = 1'b0;
  logic [OW-1:0] fpu_op;
  logic [BW-1:0] fpu_a;
  logic [BW-1:0] fpu_b;
  logic          fpu_resp_valid = 1'b0;
  logic [BW-1:0] fpu_result = '0;
  logic          stall;
  logic          out_valid;
  logic [BW-1:0] out_result;
  logic [RL-1:0] out_rd;
  logic          out_reg_write;
  logic          busy;
  logic          timeout_err;

  ex_fpu_seq #(
    .BUS_WIDTH      (BW),
    .REGFILE_LEN    (RL),
    .FPU_OP_WIDTH   (OW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_alu_fpu     (in_alu_fpu),
    .in_fpu_op      (in_fpu_op),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .flush          (flush),
    .fpu_req_valid  (fpu_req_valid),
    .fpu_req_ready  (fpu_req_ready),
    .fpu_op         (fpu_op),
    .fpu_a          (fpu_a),
    .fpu_b          (fpu_b),
    .fpu_resp_valid (fpu_resp_valid),
    .fpu_result     (fpu_result),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] exp_q[$];
  logic exp_terr = 1'b0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic scoreboard_pop(input logic [RL-1:0] rd);
    logic [BW-1:0] exp_r;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_out_valid", {63'd0, out_valid}, '0);
    end else begin
      exp_r = exp_q.pop_front();
      check("sb_result", out_result, exp_r);
      check("out_rd", {{(BW-RL){1'b0}}, out_rd}, {{(BW-RL){1'b0}}, rd});
    end
  endtask

  // Bus quiet for n cycles; nothing may move.
  task automatic drive_idle(input int n, input bit non_fpu);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      in_valid       = non_fpu;
      in_alu_fpu     = 1'b0;
      in_fpu_op      = OW'($urandom);
      in_a           = {$urandom, $urandom};
      in_b           = {$urandom, $urandom};
      in_rd          = RL'($urandom);
      in_reg_write   = 1'b1;
      flush          = 1'b0;
      fpu_req_ready  = 1'($urandom_range(0, 1));
      fpu_resp_valid = 1'b0;
      #1;
      check("idle_stall", {63'd0, stall}, '0);
      check("idle_out_valid", {63'd0, out_valid}, '0);
      check("idle_busy", {63'd0, busy}, '0);
    end
  endtask

  // One FPU instruction. rdly: ISSUE cycles before ready; wdly: WAIT cycle
  // index of the response (>= TO means none in time); kill_cyc: cycle index
  // to pulse flush (-1 none); flush_done: flush in the DONE cycle; spur: junk
  // response pulse while still in ISSUE.
  task automatic run_op(input logic [OW-1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW-1:0] res, input logic [RL-1:0] rd, input logic rw,
                        input int rdly, input int wdly, input int kill_cyc,
                        input bit flush_done, input bit spur);
    bit to;
    int w;
    int done;
    bit killed;
    bit pulse;
    to     = (wdly >= TO);
    w      = to ? TO : wdly + 1;
    done   = 2 + rdly + w;
    killed = (kill_cyc >= 1) && (kill_cyc < done);
    pulse  = !killed && !flush_done;
    if (pulse) exp_q.push_back(to ? '0 : res);
    if (to) exp_terr = 1'b1;
    for (int c = 0; c <= done; c++) begin
      @(negedge clk);
      in_valid       = 1'b1;
      in_alu_fpu     = 1'b1;
      in_fpu_op      = op;
      in_a           = a;
      in_b           = b;
      in_rd          = rd;
      in_reg_write   = rw;
      fpu_req_ready  = (c == 1 + rdly) || (c > 1 + rdly && $urandom_range(0, 1) == 1);
      fpu_resp_valid = (c == 2 + rdly + wdly) || (spur && c == 1);
      fpu_result     = (spur && c == 1) ? {$urandom, $urandom} : res;
      flush          = (c == kill_cyc) || (flush_done && c == done);
      #1;
      if (c == 0) check("busy_at_start", {63'd0, busy}, '0);
      check("stall", {63'd0, stall}, {63'd0, (c < done)});
      check("req_valid", {63'd0, fpu_req_valid}, {63'd0, (c >= 1 && c <= 1 + rdly)});
      if (c >= 1 && c <= 1 + rdly) begin
        check("req_op", {{(BW-OW){1'b0}}, fpu_op}, {{(BW-OW){1'b0}}, op});
        check("req_a", fpu_a, a);
        check("req_b", fpu_b, b);
      end
      check("out_valid", {63'd0, out_valid}, {63'd0, (pulse && c == done)});
      check("out_reg_write", {63'd0, out_reg_write}, {63'd0, (pulse && rw && c == done)});
      if (out_valid) scoreboard_pop(rd);
      if (c == done) begin
        check("busy_in_done", {63'd0, busy}, 64'd1);
        check("timeout_err", {63'd0, timeout_err}, {63'd0, exp_terr});
        if (to) check("timeout_result", out_result, '0);
      end
    end
    fpu_resp_valid = 1'b0;
  endtask

  // Reset while waiting on the FPU; a late response must be ignored.
  task automatic reset_in_wait();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid      = (c == 0);
      in_alu_fpu    = 1'b1;
      in_fpu_op     = 5'd9;
      in_a          = 64'h1111;
      in_b          = 64'h2222;
      fpu_req_ready = (c == 1);
      rst           = (c == 3);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    fpu_req_ready = 1'b0;
    exp_terr = 1'b0;
    #1;
    check("rst_busy", {63'd0, busy}, '0);
    check("rst_stall", {63'd0, stall}, '0);
    check("rst_req_valid", {63'd0, fpu_req_valid}, '0);
    check("rst_out_valid", {63'd0, out_valid}, '0);
    check("rst_out_result", out_result, '0);
    check("rst_fpu_a", fpu_a, '0);
    check("rst_out_rd", {{(BW-RL){1'b0}}, out_rd}, '0);
    check("rst_timeout_err", {63'd0, timeout_err}, '0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      fpu_resp_valid = (c == 0);
      fpu_result     = 64'hBAD0BAD0;
      #1;
      check("late_resp_out_valid", {63'd0, out_valid}, '0);
      check("late_resp_busy", {63'd0, busy}, '0);
    end
    fpu_resp_valid = 1'b0;
  endtask

  initial begin
    int rdly;
    int wdly;
    int w;
    int sel;
    int kc;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", {63'd0, busy}, '0);
    check("reset_stall", {63'd0, stall}, '0);
    check("reset_req_valid", {63'd0, fpu_req_valid}, '0);
    check("reset_out_valid", {63'd0, out_valid}, '0);
    check("reset_out_reg_write", {63'd0, out_reg_write}, '0);
    check("reset_out_result", out_result, '0);
    check("reset_fpu_op", {{(BW-OW){1'b0}}, fpu_op}, '0);
    check("reset_timeout_err", {63'd0, timeout_err}, '0);

    // Minimum latency, then long handshake with a stray early response.
    run_op(5'd3, 64'h4000000000000000, 64'h3FF0000000000000, 64'h4008000000000000,
           6'd7, 1'b1, 0, 0, -1, 1'b0, 1'b0);
    run_op(5'd4, 64'hA5A5, 64'h5A5A, 64'hC0FFEE, 6'd12, 1'b1, 4, 6, -1, 1'b0, 1'b1);
    // Response on the last allowed WAIT cycle beats the timeout.
    run_op(5'd5, 64'h1, 64'h2, 64'h77, 6'd3, 1'b0, 0, TO - 1, -1, 1'b0, 1'b0);
    drive_idle(2, 1'b1);
    // Timeout, then a response arriving one cycle too late (lands in DONE).
    run_op(5'd6, 64'h3, 64'h4, 64'h99, 6'd4, 1'b1, 1, 255, -1, 1'b0, 1'b0);
    run_op(5'd7, 64'h5, 64'h6, 64'h98, 6'd5, 1'b1, 0, TO, -1, 1'b0, 1'b0);
    // Flush in WAIT, then back-to-back instructions.
    run_op(5'd8, 64'h7, 64'h8, 64'h1234, 6'd6, 1'b1, 0, 3, 3, 1'b0, 1'b0);
    run_op(5'd9, 64'h9, 64'hA, 64'h5678, 6'd8, 1'b1, 0, 1, -1, 1'b0, 1'b0);
    run_op(5'd10, 64'hB, 64'hC, 64'h9ABC, 6'd9, 1'b1, 2, 0, -1, 1'b0, 1'b0);
    // Flush in ISSUE, flush in DONE.
    run_op(5'd11, 64'hD, 64'hE, 64'h4321, 6'd10, 1'b1, 2, 2, 2, 1'b0, 1'b0);
    run_op(5'd12, 64'hF, 64'h10, 64'h8765, 6'd11, 1'b1, 0, 2, -1, 1'b1, 1'b0);
    drive_idle(3, 1'b1);
    reset_in_wait();

    for (int i = 0; i < 40; i++) begin
      rdly = $urandom_range(0, 4);
      wdly = $urandom_range(0, TO + 1);
      w    = (wdly >= TO) ? TO : wdly + 1;
      sel  = $urandom_range(0, 6);
      kc   = -1;
      if (sel == 0) kc = 1 + $urandom_range(0, rdly);
      if (sel == 1) kc = 2 + rdly + $urandom_range(0, w - 1);
      run_op(OW'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             RL'($urandom), 1'($urandom_range(0, 1)), rdly, wdly, kc, (sel == 2), (sel == 3));
      if ($urandom_range(0, 3) == 0) drive_idle($urandom_range(1, 2), 1'($urandom_range(0, 1)));
    end

    drive_idle(2, 1'b0);
    check("sb_empty", 64'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
